// File: rtl/coef_seq_mult.sv
// coef_seq_mult: sequential constant multiplier.
// Takes one unsigned operand per transaction and emits operand*C[k] for
// k = 0..N_COEF-1 on consecutive beats. Each product is built by shift-add.
// A new operand can be accepted on the last beat, so there is no bubble.
module coef_seq_mult #(
  parameter int          DW     = 8,
  parameter int          N_COEF = 4,
  parameter logic [3:0]  C0     = 4'd1,
  parameter logic [3:0]  C1     = 4'd3,
  parameter logic [3:0]  C2     = 4'd7,
  parameter logic [3:0]  C3     = 4'd8,
  localparam int         OW     = DW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          d_valid,
  output logic          input_grant,
  input  logic          hold,
  output logic [OW-1:0] out,
  output logic          out_valid,
  output logic [1:0]    out_idx,
  output logic          out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(N_COEF - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q,  data_d;
  logic [1:0]    idx_q,   idx_d;
  logic [3:0]    coef;
  logic          last_beat;

  // Sum of (x << b) over the set bits b of the 4-bit coefficient c.
  // The 4 extra output bits cover 15 * (2^DW - 1), so the sum never wraps.
  function automatic logic [OW-1:0] shift_add(input logic [DW-1:0] x,
                                              input logic [3:0]    c);
    logic [OW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 4; b++) begin
      if (c[b]) acc = acc + ({4'b0000, x} << b);
    end
    return acc;
  endfunction

  // Coefficient for the beat currently on the output.
  always_comb begin
    coef = C0;
    case (idx_q)
      2'd0:    coef = C0;
      2'd1:    coef = C1;
      2'd2:    coef = C2;
      default: coef = C3;
    endcase
  end

  assign last_beat = (state_q == RUN) && (idx_q == LAST_IDX);

  // State, operand and beat index registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: accept in IDLE or on an unstalled last beat, else step idx.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (d_valid) begin
          data_d  = d;
          idx_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (!last_beat) begin
            idx_d = idx_q + 2'd1;
          end else if (d_valid) begin
            data_d = d;
            idx_d  = 2'd0;
          end else begin
            idx_d   = 2'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registers, plus hold for the grant.
  always_comb begin
    input_grant = (state_q == IDLE) || (last_beat && !hold);
    out_valid   = (state_q == RUN);
    out_last    = last_beat;
    out_idx     = (state_q == RUN) ? idx_q : 2'd0;
    out         = (state_q == RUN) ? shift_add(data_q, coef) : '0;
  end

endmodule

// File: tb/tb_coef_seq_mult.sv
// Directed testbench for coef_seq_mult: default instance (DW=8, coefficients
// 1/3/7/8) and a DW=4, N_COEF=2, coefficients 0/15 instance.
module tb_coef_seq_mult;

  logic        clk;
  logic        rst;

  logic [7:0]  d;
  logic        d_valid;
  logic        hold;
  logic        grant;
  logic [11:0] out;
  logic        out_valid;
  logic [1:0]  out_idx;
  logic        out_last;

  logic [3:0]  d4;
  logic        d_valid4;
  logic        hold4;
  logic        grant4;
  logic [7:0]  out4;
  logic        out_valid4;
  logic [1:0]  out_idx4;
  logic        out_last4;

  int checks;
  int errors;

  coef_seq_mult u_dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .d_valid     (d_valid),
    .input_grant (grant),
    .hold        (hold),
    .out         (out),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_last    (out_last)
  );

  coef_seq_mult #(
    .DW     (4),
    .N_COEF (2),
    .C0     (4'd0),
    .C1     (4'd15),
    .C2     (4'd0),
    .C3     (4'd0)
  ) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .d           (d4),
    .d_valid     (d_valid4),
    .input_grant (grant4),
    .hold        (hold4),
    .out         (out4),
    .out_valid   (out_valid4),
    .out_idx     (out_idx4),
    .out_last    (out_last4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out !== 12'd0 || grant !== 1'b1 ||
          out_idx !== 2'd0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: valid=%b out=%0d grant=%b idx=%0d last=%b, want 0/0/1/0/0",
                 c, out_valid, out, grant, out_idx, out_last);
      end
      checks++;
      if (out_valid4 !== 1'b0 || grant4 !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle4 cyc%0d: valid=%b grant=%b, want 0/1", c, out_valid4, grant4);
      end
    end
  endtask

  task automatic test_single();
    logic [11:0] e [4];
    e[0] = 12'd255; e[1] = 12'd765; e[2] = 12'd1785; e[3] = 12'd2040;
    @(posedge clk); #1;
    d = 8'hFF; d_valid = 1'b1; hold = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      d_valid = 1'b0;
      #1;
      checks++;
      if (out !== e[j] || out_valid !== 1'b1 || out_idx !== 2'(j) ||
          out_last !== (j == 3) || grant !== (j == 3)) begin
        errors++;
        $display("FAIL single beat%0d: out=%0d valid=%b idx=%0d last=%b grant=%b, want out=%0d idx=%0d last=%b grant=%b",
                 j, out, out_valid, out_idx, out_last, grant, e[j], j, (j == 3), (j == 3));
      end
    end
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b0 || out !== 12'd0 || grant !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: valid=%b out=%0d grant=%b, want 0/0/1", out_valid, out, grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e [8];
    e[0] = 12'd3;  e[1] = 12'd9;  e[2] = 12'd21; e[3] = 12'd24;
    e[4] = 12'd10; e[5] = 12'd30; e[6] = 12'd70; e[7] = 12'd80;
    @(posedge clk); #1;
    d = 8'd3; d_valid = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      d = 8'd10;
      if (j == 7) d_valid = 1'b0;
      #1;
      checks++;
      if (out !== e[j] || out_valid !== 1'b1 || out_idx !== 2'(j % 4) ||
          out_last !== (j % 4 == 3) || grant !== (j % 4 == 3)) begin
        errors++;
        $display("FAIL b2b beat%0d: out=%0d valid=%b idx=%0d last=%b grant=%b, want out=%0d idx=%0d last/grant=%b",
                 j, out, out_valid, out_idx, out_last, grant, e[j], j % 4, (j % 4 == 3));
      end
    end
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b0 || grant !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b grant=%b, want 0/1", out_valid, grant);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    d = 8'd5; d_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    #1;
    checks++;
    if (out !== 12'd5 || out_idx !== 2'd0) begin
      errors++;
      $display("FAIL bp_beat0: out=%0d idx=%0d, want 5/0", out, out_idx);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      hold = (c < 3);
      #1;
      checks++;
      if (out !== 12'd15 || out_idx !== 2'd1 || out_valid !== 1'b1 || grant !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: out=%0d idx=%0d valid=%b grant=%b, want 15/1/1/0",
                 c, out, out_idx, out_valid, grant);
      end
    end
    @(posedge clk); #2;
    checks++;
    if (out !== 12'd35 || out_idx !== 2'd2) begin
      errors++;
      $display("FAIL bp_beat2: out=%0d idx=%0d, want 35/2", out, out_idx);
    end
    // Stall the last beat while a new operand is offered: it must be refused.
    @(posedge clk); #1;
    hold = 1'b1; d = 8'd9; d_valid = 1'b1;
    #1;
    checks++;
    if (out !== 12'd40 || out_last !== 1'b1 || grant !== 1'b0) begin
      errors++;
      $display("FAIL bp_last_held: out=%0d last=%b grant=%b, want 40/1/0", out, out_last, grant);
    end
    @(posedge clk); #1;
    hold = 1'b0; d_valid = 1'b0;
    #1;
    checks++;
    if (out !== 12'd40 || out_idx !== 2'd3 || grant !== 1'b1) begin
      errors++;
      $display("FAIL bp_last_release: out=%0d idx=%0d grant=%b, want 40/3/1", out, out_idx, grant);
    end
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b0 || out !== 12'd0) begin
      errors++;
      $display("FAIL bp_idle: valid=%b out=%0d, want 0/0", out_valid, out);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    d = 8'd7; d_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checks++;
    if (out !== 12'd49 || out_idx !== 2'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat2: out=%0d idx=%0d valid=%b, want 49/2/1", out, out_idx, out_valid);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 12'd0 || out_idx !== 2'd0 || grant !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: valid=%b out=%0d idx=%0d grant=%b, want 0/0/0/1",
               out_valid, out, out_idx, grant);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b0 || grant !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: valid=%b grant=%b last=%b, want 0/1/0", out_valid, grant, out_last);
    end
  endtask

  task automatic test_variant();
    @(posedge clk); #1;
    d4 = 4'hF; d_valid4 = 1'b1; hold4 = 1'b0;
    #1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j == 5) d_valid4 = 1'b0;
      #1;
      checks++;
      if (out4 !== ((j % 2) ? 8'd225 : 8'd0) || out_valid4 !== 1'b1 ||
          out_idx4 !== 2'(j % 2) || out_last4 !== (j % 2 == 1) || grant4 !== (j % 2 == 1)) begin
        errors++;
        $display("FAIL variant beat%0d: out=%0d valid=%b idx=%0d last=%b grant=%b, want out=%0d idx=%0d last/grant=%b",
                 j, out4, out_valid4, out_idx4, out_last4, grant4,
                 (j % 2) ? 225 : 0, j % 2, (j % 2 == 1));
      end
    end
    @(posedge clk); #2;
    checks++;
    if (out_valid4 !== 1'b0 || out4 !== 8'd0 || grant4 !== 1'b1) begin
      errors++;
      $display("FAIL variant_idle: valid=%b out=%0d grant=%b, want 0/0/1", out_valid4, out4, grant4);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    d        = 8'd0;
    d_valid  = 1'b0;
    hold     = 1'b0;
    d4       = 4'd0;
    d_valid4 = 1'b0;
    hold4    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_variant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_seq_mult.md
# coef_seq_mult

Parametrised sequential constant-multiplier. Accepts one unsigned operand per transaction and presents the products operand×C0, operand×C1, … operand×C(N_COEF-1) on consecutive output beats. Each product is formed by shift-add over the coefficient bits. It generalises the fixed ×1/×3/×7/×8 sequencer with parametrised width, coefficient count and values, an input valid/grant handshake, output backpressure and back-to-back operand acceptance. It sits between a sample source and downstream arithmetic.

## Interface
- DW, 8: operand width.
- N_COEF, 4: number of coefficients per operand, legal range 1..4.
- C0, 1: coefficient 0, unsigned 4-bit (0..15).
- C1, 3: coefficient 1, unsigned 4-bit.
- C2, 7: coefficient 2, unsigned 4-bit.
- C3, 8: coefficient 3, unsigned 4-bit.
- OW, DW+4: output width (derived, not overridden).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- d  in  DW  operand.
- d_valid  in  1  operand present on d.
- input_grant  out  1  block accepts d this cycle; a transfer occurs when d_valid && input_grant at a rising edge.
- hold  in  1  downstream stall; freezes the current output beat.
- out  out  OW  product, unsigned.
- out_valid  out  1  out carries a valid product.
- out_idx  out  2  coefficient index of the current beat.
- out_last  out  1  current beat is index N_COEF-1.

## Operation
- Registers: state {IDLE, RUN}, i_data[DW-1:0], idx[1:0].
- Reset (async, rst=0): state=IDLE, i_data=0, idx=0. Outputs during and after reset: out_valid=0, out=0, out_idx=0, out_last=0, input_grant=1.
- IDLE:
  - input_grant=1, out_valid=0, out=0.
  - On transfer: i_data<=d, idx<=0, state<=RUN.
- RUN:
  - out_valid=1, out_idx=idx, out=i_data×C[idx].
  - out_last=(idx==N_COEF-1).
  - If hold=1: all registers hold, input_grant=0.
  - If hold=0 and not last: idx<=idx+1.
  - If hold=0 and last: input_grant=1.
    - On transfer: i_data<=d, idx<=0, stay in RUN (back-to-back, no bubble).
    - Otherwise: state<=IDLE, idx<=0.
- input_grant = (state==IDLE) || (state==RUN && out_last && !hold). It is combinational from registered state and hold only, and never depends on d_valid.
- When input_grant=0, d_valid is ignored and d is not sampled.
- Arithmetic:
  - out = sum over set bits b of C[idx] of (i_data << b), zero-extended to OW.
  - Realised as shift-add, not a generic multiplier.
  - OW=DW+4 holds 15×(2^DW−1) without overflow.
  - Coefficient 0 yields a valid beat with out=0.
- N_COEF=1: every RUN beat is last; sustained throughput is one operand per cycle.
- Reset mid-transaction aborts it. The remaining beats are dropped and the block returns to IDLE.

## Timing
- Operand accepted at edge k: beat 0 is visible in the cycle after edge k. Beat j is visible after edge k+j, given no hold.
- Each beat holds for 1+H cycles, where H is the number of hold cycles applied to it.
- Throughput: one operand per N_COEF cycles when d_valid is continuously high and hold=0.
- From IDLE: 1 cycle of acceptance latency, no extra idle cycle.
- out, out_idx, out_last and out_valid are driven combinationally from registers only, so they are glitch-safe for downstream registering.
- hold in IDLE has no effect.
- hold asserted on the last beat blocks acceptance until hold drops.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then d_valid=0 → out_valid=0, out=0, input_grant=1 throughout.
- Single operand, defaults: d=8'hFF with d_valid for one cycle → beats 255, 765, 1785, 2040 with out_idx 0..3, and out_last only on 2040. Then IDLE with out_valid=0.
- Back-to-back: d_valid held high, d=3 then d=10 → 3, 9, 21, 24, 10, 30, 70, 80 with no gap. input_grant high only on the beats with idx=3.
- Backpressure: d=5, hold=1 for 3 cycles on beat idx=1 → out=15 held for 4 cycles, input_grant=0 throughout. Sequence then completes with 35, 40.
- Reset mid-operation: d=7 accepted, rst pulsed low during beat idx=2 → out_valid drops immediately with no clock edge needed. After release: IDLE and input_grant=1.
- Parameter variant: DW=4, N_COEF=2, C0=0, C1=15, d=4'hF → beats 0 then 225 (OW=8). Back-to-back operands produce alternating 0/225 with out_last on every second cycle.
